// File: rtl/mmio_bridge.sv
// mmio_bridge: data-memory bridge between the processor dmem port and RAM.
// Decodes a 256-word MMIO window at MMIO_BASE that holds debounced buttons,
// an optional PS/2 scancode FIFO and N_OUT writable output registers. Loads
// from either source return data one cycle after the request.
//
// Optional feature macro: MMIO_KB_FIFO_EN (scancode FIFO at offsets 2 and 3).
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   wren, ren           processor store / load strobes
//   address_dmem, data  processor word address and store data
//   q_dmem              load data (valid the cycle after ren)
//   ram_wEn, ram_addr, ram_dataIn, ram_dataOut   RAM port
//   btn_raw             asynchronous button inputs
//   kb_data, kb_valid   PS/2 scancode and its one-cycle strobe
//   out_regs            output registers, channel k at [k*DATA_W +: DATA_W]
module mmio_bridge #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hF00,
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH = 8,
  parameter int N_OUT = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wren,
  input  logic                      ren,
  input  logic [ADDR_W-1:0]         address_dmem,
  input  logic [DATA_W-1:0]         data,
  output logic [DATA_W-1:0]         q_dmem,
  output logic                      ram_wEn,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_dataIn,
  input  logic [DATA_W-1:0]         ram_dataOut,
  input  logic [N_BTN-1:0]          btn_raw,
  input  logic [7:0]                kb_data,
  input  logic                      kb_valid,
  output logic [N_OUT*DATA_W-1:0]   out_regs
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [ADDR_W-1:0] offset;
  logic [31:0]       off_i;
  logic              is_mmio;
  logic              rd_fire;
  logic              wr_mmio;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_q;
  logic              sel_ram;

  assign offset   = address_dmem - MMIO_BASE;
  assign off_i    = 32'(offset);
  assign is_mmio  = (address_dmem >= MMIO_BASE) && (off_i < 32'd256);
  // Read side effects only apply to pure loads.
  assign rd_fire  = ren & ~wren & is_mmio;
  assign wr_mmio  = wren & is_mmio;

  assign ram_addr   = address_dmem;
  assign ram_dataIn = data;
  assign ram_wEn    = wren & ~is_mmio;

  // Buttons: 2-flop synchronizer, then per-channel stability counter.
  logic [N_BTN-1:0] sync1, sync2, level, edges, rise;
  logic [CW-1:0]    cnt [N_BTN];
  logic             clr_edge;

  assign clr_edge = rd_fire && (off_i == 32'd1);

  always_comb begin
    rise = '0;
    for (int unsigned k = 0; k < N_BTN; k++)
      rise[k] = (sync2[k] != level[k]) && (cnt[k] == CNT_LAST) && !level[k];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      edges <= '0;
      for (int unsigned k = 0; k < N_BTN; k++) cnt[k] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int unsigned k = 0; k < N_BTN; k++) begin
        if (sync2[k] == level[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          cnt[k]   <= '0;
          level[k] <= ~level[k];
        end else begin
          cnt[k] <= cnt[k] + CW'(1);
        end
      end
      // A new edge in the clearing cycle survives; all other bits clear.
      edges <= (edges & ~{N_BTN{clr_edge}}) | rise;
    end
  end

`ifdef MMIO_KB_FIFO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   kb_count;
  logic          kb_ovf, kb_full, kb_empty, kb_pop, kb_push, ovf_set, clr_ovf;

  assign kb_full  = (kb_count == (PW+1)'(FIFO_DEPTH));
  assign kb_empty = (kb_count == '0);
  assign kb_pop   = rd_fire && (off_i == 32'd3) && !kb_empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign kb_push  = kb_valid && (!kb_full || kb_pop);
  assign ovf_set  = kb_valid && kb_full && !kb_pop;
  assign clr_ovf  = rd_fire && (off_i == 32'd2);

  always_ff @(posedge clock) begin
    if (kb_push) fifo_mem[wr_ptr] <= kb_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      kb_count <= '0;
      kb_ovf   <= 1'b0;
    end else begin
      if (kb_push) wr_ptr <= wr_ptr + PW'(1);
      if (kb_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (kb_push && !kb_pop)      kb_count <= kb_count + (PW+1)'(1);
      else if (kb_pop && !kb_push) kb_count <= kb_count - (PW+1)'(1);
      if (ovf_set)      kb_ovf <= 1'b1;
      else if (clr_ovf) kb_ovf <= 1'b0;
    end
  end
`else
  logic kb_unused;
  assign kb_unused = ^{kb_data, kb_valid};
`endif

  // Output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_regs <= '0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++)
        if (wr_mmio && (off_i == 32'(4 + k)))
          out_regs[k*DATA_W +: DATA_W] <= data;
    end
  end

  // MMIO read mux.
  always_comb begin
    rdata = '0;
    case (off_i)
      32'd0: rdata[N_BTN-1:0] = level;
      32'd1: rdata[N_BTN-1:0] = edges;
`ifdef MMIO_KB_FIFO_EN
      32'd2: begin
        rdata[0]    = !kb_empty;
        rdata[1]    = kb_full;
        rdata[2]    = kb_ovf;
        rdata[15:8] = 8'(kb_count);
      end
      32'd3: if (!kb_empty) rdata[7:0] = fifo_mem[rd_ptr];
`endif
      default: begin
        for (int unsigned k = 0; k < N_OUT; k++)
          if (off_i == 32'(4 + k)) rdata = out_regs[k*DATA_W +: DATA_W];
      end
    endcase
  end

  // Load path: MMIO data is registered; RAM data is steered by a select flop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel_ram <= 1'b0;
      rd_q    <= '0;
    end else if (ren) begin
      sel_ram <= ~is_mmio;
      rd_q    <= is_mmio ? rdata : '0;
    end
  end

  assign q_dmem = sel_ram ? ram_dataOut : rd_q;

endmodule

// File: tb/tb_mmio_bridge.sv
module tb_mmio_bridge;

  logic         clock = 1'b0;
  logic         reset;
  logic         wren, ren;
  logic [11:0]  address_dmem;
  logic [31:0]  data;
  logic [31:0]  q_dmem;
  logic         ram_wEn;
  logic [11:0]  ram_addr;
  logic [31:0]  ram_dataIn;
  logic [31:0]  ram_dataOut;
  logic [3:0]   btn_raw;
  logic [7:0]   kb_data;
  logic         kb_valid;
  logic [127:0] out_regs;

  int checks = 0;
  int errors = 0;

`ifdef MMIO_KB_FIFO_EN
  localparam bit KB = 1'b1;
`else
  localparam bit KB = 1'b0;
`endif

  mmio_bridge #(
    .ADDR_W(12), .DATA_W(32), .MMIO_BASE(12'hF00), .N_BTN(4),
    .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4), .N_OUT(4)
  ) dut (
    .clock(clock), .reset(reset), .wren(wren), .ren(ren),
    .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut), .btn_raw(btn_raw), .kb_data(kb_data),
    .kb_valid(kb_valid), .out_regs(out_regs)
  );

  always #5 clock = ~clock;

  // Synchronous RAM model with one-cycle read latency.
  logic [31:0] ram_mem [4096];
  always @(posedge clock) begin
    if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= ram_mem[ram_addr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] kbx(input logic [31:0] v);
    return KB ? v : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    address_dmem = a; data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic load(input logic [11:0] a, output logic [31:0] q);
    address_dmem = a; ren = 1'b1;
    tick();
    ren = 1'b0;
    q = q_dmem;
  endtask

  task automatic push(input logic [7:0] b);
    kb_data = b; kb_valid = 1'b1;
    tick();
    kb_valid = 1'b0;
  endtask

  logic [31:0] q;
  logic [7:0]  bytes5 [5];

  initial begin
    reset = 1'b0; wren = 1'b0; ren = 1'b0; address_dmem = '0; data = '0;
    btn_raw = '0; kb_data = '0; kb_valid = 1'b0;
    tick(3);
    chk("reset_q", 128'(q_dmem), 128'h0);
    chk("reset_out", out_regs, 128'h0);
    reset = 1'b1;
    tick();

    // RAM path
    address_dmem = 12'h010; data = 32'hDEADBEEF; wren = 1'b1;
    #1;
    chk("ram_wen_store", 128'(ram_wEn), 128'h1);
    chk("ram_addr_store", 128'(ram_addr), 128'h010);
    chk("ram_din_store", 128'(ram_dataIn), 128'hDEADBEEF);
    tick();
    wren = 1'b0;
    store(12'h020, 32'h12345678);
    load(12'h010, q); chk("ram_load_010", 128'(q), 128'hDEADBEEF);
    load(12'h020, q); chk("ram_load_020", 128'(q), 128'h12345678);

    // Output registers
    address_dmem = 12'hF05; data = 32'h123; wren = 1'b1;
    #1;
    chk("mmio_store_no_ram_wen", 128'(ram_wEn), 128'h0);
    tick();
    wren = 1'b0;
    chk("out1_visible", 128'(out_regs[63:32]), 128'h123);
    chk("out0_untouched", 128'(out_regs[31:0]), 128'h0);
    store(12'hF00, 32'hFFFFFFFF);
    load(12'hF00, q); chk("btn_level_ro", 128'(q), 128'h0);
    load(12'hF05, q); chk("out1_read", 128'(q), 128'h123);
    store(12'hF07, 32'hAAAA5555);
    chk("out3_visible", 128'(out_regs[127:96]), 128'hAAAA5555);
    store(12'hF08, 32'h99);
    load(12'hF08, q); chk("unused_off_read", 128'(q), 128'h0);
    chk("out_regs_after_unused_store", out_regs,
        {32'hAAAA5555, 32'h0, 32'h123, 32'h0});
    // wren+ren together: store happens, old data returned
    address_dmem = 12'hF06; data = 32'h77; wren = 1'b1; ren = 1'b1;
    tick();
    wren = 1'b0; ren = 1'b0;
    chk("rw_same_cycle_old", 128'(q_dmem), 128'h0);
    load(12'hF06, q); chk("rw_same_cycle_new", 128'(q), 128'h77);

    // Button bounce: 3-cycle pulses never qualify
    for (int i = 0; i < 3; i++) begin
      btn_raw[2] = 1'b1; tick(3);
      btn_raw[2] = 1'b0; tick(3);
    end
    tick(6);
    load(12'hF00, q); chk("bounce_level", 128'(q), 128'h0);
    load(12'hF01, q); chk("bounce_edge", 128'(q), 128'h0);

    // Button hold: level changes 6 cycles after raw change
    btn_raw[2] = 1'b1;
    tick(5);
    load(12'hF00, q); chk("btn_level_early", 128'(q), 128'h0);
    load(12'hF00, q); chk("btn_level", 128'(q), 128'h4);
    load(12'hF01, q); chk("btn_edge", 128'(q), 128'h4);
    load(12'hF01, q); chk("btn_edge_cleared", 128'(q), 128'h0);

    // Clearing read coincides with a new edge on another bit
    btn_raw[0] = 1'b1;
    tick(3);
    btn_raw[1] = 1'b1;
    tick(5);
    load(12'hF01, q); chk("edge_race_old", 128'(q), 128'h1);
    load(12'hF01, q); chk("edge_race_new_kept", 128'(q), 128'h2);
    load(12'hF00, q); chk("level_three", 128'(q), 128'h7);
    btn_raw[2] = 1'b0;
    tick(8);
    load(12'hF00, q); chk("level_fall", 128'(q), 128'h3);
    load(12'hF01, q); chk("fall_no_edge", 128'(q), 128'h0);

    // Scancode FIFO
    push(8'h5A);
    load(12'hF02, q); chk("kb_push_visible", 128'(q), 128'(kbx(32'h101)));
    load(12'hF03, q); chk("kb_pop_single", 128'(q), 128'(kbx(32'h5A)));
    bytes5 = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};
    for (int i = 0; i < 5; i++) push(bytes5[i]);
    load(12'hF02, q); chk("kb_status_full_ovf", 128'(q), 128'(kbx(32'h407)));
    for (int i = 0; i < 4; i++) begin
      load(12'hF03, q); chk("kb_pop", 128'(q), 128'(kbx(32'(bytes5[i]))));
    end
    load(12'hF03, q); chk("kb_pop_empty", 128'(q), 128'h0);
    load(12'hF02, q); chk("kb_status_empty", 128'(q), 128'h0);
    // push+pop while full
    for (int i = 1; i <= 4; i++) push(8'(i));
    address_dmem = 12'hF03; ren = 1'b1; kb_data = 8'h05; kb_valid = 1'b1;
    tick();
    ren = 1'b0; kb_valid = 1'b0;
    chk("kb_pushpop_full_data", 128'(q_dmem), 128'(kbx(32'h01)));
    load(12'hF02, q); chk("kb_pushpop_full_status", 128'(q), 128'(kbx(32'h403)));
    for (int i = 2; i <= 5; i++) begin
      load(12'hF03, q); chk("kb_pop_after_pushpop", 128'(q), 128'(kbx(32'(i))));
    end
    // push+pop while empty
    address_dmem = 12'hF03; ren = 1'b1; kb_data = 8'h66; kb_valid = 1'b1;
    tick();
    ren = 1'b0; kb_valid = 1'b0;
    chk("kb_pushpop_empty_data", 128'(q_dmem), 128'h0);
    load(12'hF02, q); chk("kb_pushpop_empty_status", 128'(q), 128'(kbx(32'h101)));

    // Mid-operation reset
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    store(12'hF04, 32'h55);
    btn_raw = '0;
    load(12'hF04, q); chk("pre_reset_out0", 128'(q), 128'h55);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("post_reset_q", 128'(q_dmem), 128'h0);
    chk("post_reset_out", out_regs, 128'h0);
    load(12'hF02, q); chk("post_reset_kb_status", 128'(q), 128'h0);
    load(12'hF03, q); chk("post_reset_kb_data", 128'(q), 128'h0);
    load(12'hF05, q); chk("post_reset_out1", 128'(q), 128'h0);
    load(12'hF00, q); chk("post_reset_level", 128'(q), 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
